// File: rtl/shift.sv
// Registered 32-bit barrel shifter: SLL, SRL or SRA of B by A[4:0], chosen by ALUFun.
// Separate left and right five-stage shift networks; anything outside the three shift codes yields zero.
module shift (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  output logic [31:0] S
);

  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;

  logic [4:0]       amt;
  logic             fill;
  logic [5:0][31:0] left_stage;
  logic [5:0][31:0] right_stage;
  logic [31:0]      s_next;
  logic             unused_a_hi;

  assign amt         = A[4:0];
  assign unused_a_hi = ^A[31:5];
  assign fill        = (ALUFun == FUN_SRA) ? B[31] : 1'b0;

  assign left_stage[0]  = B;
  assign right_stage[0] = B;

  // Stage gi shifts by 16 >> gi, enabled by amount bit 4-gi.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 16 >> gi;
      assign left_stage[gi+1] = amt[4-gi]
        ? {left_stage[gi][31-SH:0], {SH{1'b0}}}
        : left_stage[gi];
      assign right_stage[gi+1] = amt[4-gi]
        ? {{SH{fill}}, right_stage[gi][31:SH]}
        : right_stage[gi];
    end
  endgenerate

  always_comb begin
    s_next = 32'h0000_0000;
    case (ALUFun)
      FUN_SLL: s_next = left_stage[5];
      FUN_SRL,
      FUN_SRA: s_next = right_stage[5];
      default: s_next = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) S <= 32'h0000_0000;
    else       S <= s_next;
  end

endmodule

// File: tb/tb_shift.sv
// Self-checking bench for shift: directed vectors, reset cases and random
// stimulus compared against an arithmetic reference model.
module tb_shift;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALUFun;
  logic [31:0] S;

  int tests = 0;
  int fails = 0;

  shift dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ALUFun (ALUFun),
    .S      (S)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100011;

  // Reference result straight from the operation definitions.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f);
    int unsigned        n;
    logic signed [31:0] sb;
    n  = a % 32;
    sb = b;
    case (f)
      F_SLL:   return b << n;
      F_SRL:   return b >> n;
      F_SRA:   return sb >>> n;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    tests++;
    assert (S === exp) else begin
      fails++;
      $error("FAIL %s: S=%h expected=%h", tag, S, exp);
    end
  endtask

  // Apply one set of inputs, clock once, and compare S just after the edge.
  task automatic step(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] f,
                      input logic [31:0] exp);
    reset = r; A = a; B = b; ALUFun = f;
    @(posedge clk);
    #1;
    check(tag, exp);
    $display("[TB] %s reset=%0b A=%h B=%h ALUFun=%b S=%h exp=%h",
             tag, r, a, b, f, S, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    reset = 1'b1; A = '0; B = '0; ALUFun = '0;

    step("reset_a", 1'b1, 32'h8, 32'hB38F0F83, F_SLL, 32'h0);
    step("reset_b", 1'b1, 32'h0, 32'hFFFFFFFF, F_SRL, 32'h0);
    step("first_after_reset", 1'b0, 32'h8, 32'hB38F0F83, F_SLL, 32'h8F0F8300);

    step("v23_sll", 1'b0, 32'h8, 32'hB38F0F83, F_SLL, 32'h8F0F8300);
    step("v23_srl", 1'b0, 32'h8, 32'hB38F0F83, F_SRL, 32'h00B38F0F);
    step("v23_sra", 1'b0, 32'h8, 32'hB38F0F83, F_SRA, 32'hFFB38F0F);
    step("v24_sll", 1'b0, 32'hFFFFFFF7, 32'h4C70F07C, F_SLL, 32'h3E000000);
    step("v24_srl", 1'b0, 32'hFFFFFFF7, 32'h4C70F07C, F_SRL, 32'h00000098);
    step("v24_sra", 1'b0, 32'hFFFFFFF7, 32'h4C70F07C, F_SRA, 32'h00000098);
    step("v25_sll", 1'b0, 32'h0, 32'hDEADBEEF, F_SLL, 32'hDEADBEEF);
    step("v25_srl", 1'b0, 32'h0, 32'hDEADBEEF, F_SRL, 32'hDEADBEEF);
    step("v25_sra", 1'b0, 32'h0, 32'hDEADBEEF, F_SRA, 32'hDEADBEEF);
    step("v26_sra", 1'b0, 32'd31, 32'h80000000, F_SRA, 32'hFFFFFFFF);
    step("v26_srl", 1'b0, 32'd31, 32'h80000000, F_SRL, 32'h00000001);
    step("v26_sll", 1'b0, 32'd31, 32'h80000000, F_SLL, 32'h00000000);
    step("v26_sll_lsb", 1'b0, 32'd31, 32'h00000001, F_SLL, 32'h80000000);
    step("v27_100010", 1'b0, 32'h3, 32'hFFFFFFFF, 6'b100010, 32'h0);
    step("v27_000000", 1'b0, 32'h3, 32'hFFFFFFFF, 6'b000000, 32'h0);
    step("low5_only", 1'b0, 32'h0000_0021, 32'h0000_00F0, F_SRL, 32'h0000_0078);

    // Mid-stream reset discards the pending result.
    step("v28_pre", 1'b0, 32'h4, 32'h12345678, F_SRL, 32'h01234567);
    step("v28_reset", 1'b1, 32'h8, 32'hB38F0F83, F_SLL, 32'h0);
    step("v28_resume", 1'b0, 32'h8, 32'hB38F0F83, F_SLL, 32'h8F0F8300);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rf = F_SLL;
        1: rf = F_SRL;
        2: rf = F_SRA;
        3: rf = 6'b100010;
        default: rf = 6'($urandom);
      endcase
      if (i % 50 == 0) rb[31] = 1'b1;
      step("random", 1'b0, ra, rb, rf, model(ra, rb, rf));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift.md
SHIFT -- requirements
Module: shift

Interface
REQ-001 Parameters: none; the data width is fixed at 32 bits and the shift-amount width at 5 bits.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 A  input  32  shift-amount operand; only A[4:0] is used and A[31:5] SHALL be ignored.
REQ-005 B  input  32  data operand to be shifted.
REQ-006 ALUFun  input  6  operation select from the ALU decoder.
REQ-007 S  output  32  registered shift result.

Function
REQ-008 Operation decode SHALL use the full ALUFun value:
- 6'b100000 = SLL (logical left shift).
- 6'b100001 = SRL (logical right shift).
- 6'b100011 = SRA (arithmetic right shift).
REQ-009 SLL SHALL compute B << A[4:0], filling vacated low bits with 0.
REQ-010 SRL SHALL compute B >> A[4:0], filling vacated high bits with 0.
REQ-011 SRA SHALL compute B >> A[4:0], filling vacated high bits with B[31].
REQ-012 Any other ALUFun value, including 6'b100010, SHALL produce a result of 32'h0000_0000.
REQ-013 The shifter SHALL be a combinational 5-stage barrel shifter:
- Stages shift by 16, 8, 4, 2, 1, enabled by A[4], A[3], A[2], A[1], A[0] respectively.
- The left-shift path and the right-shift path are separate.
- The right-shift fill bit is B[31] for SRA and 0 for SRL.
REQ-014 The combinational result SHALL be registered into S on every rising clk edge when reset is low; latency is exactly 1 cycle.
REQ-015 Inputs sampled at edge N SHALL appear on S after edge N, and S SHALL hold that value until edge N+1.
REQ-016 Boundary behaviour:
- A[4:0]=0 SHALL pass B through unchanged for all three operations.
- A[4:0]=31 SHALL leave only one original bit in S, or all sign bits for SRA.
REQ-017 S SHALL be updated every cycle; there is no handshake, enable, or stall.
REQ-018 S SHALL have no X or undefined states for any input combination once reset has been applied.

Reset
REQ-019 When reset is high at a rising clk edge, S SHALL become 32'h0000_0000, regardless of A, B, and ALUFun.
REQ-020 If reset is asserted mid-stream, the previously pipelined result SHALL be discarded and never appear on S.
REQ-021 On the first edge with reset low, S SHALL take the result of the inputs present at that edge.
REQ-022 S SHALL be undefined from power-up until the first reset edge.

Verification
REQ-023 A=32'h8, B=32'hB38F0F83 -> S after 1 cycle:
- SLL = 32'h8F0F8300.
- SRL = 32'h00B38F0F.
- SRA = 32'hFFB38F0F.
REQ-024 A=32'hFFFFFFF7 (amount 23, upper bits ignored), B=32'h4C70F07C -> S:
- SLL = 32'h3E000000.
- SRL = 32'h00000098.
- SRA = 32'h00000098.
REQ-025 A=32'h0, B=32'hDEADBEEF -> S = 32'hDEADBEEF for SLL, SRL, and SRA.
REQ-026 A=32'd31, B=32'h80000000 -> S:
- SRA = 32'hFFFFFFFF.
- SRL = 32'h00000001.
- SLL = 32'h00000000.
REQ-027 ALUFun=6'b100010 or 6'b000000, B=32'hFFFFFFFF -> S = 32'h00000000.
REQ-028 Reset high for one edge while the SLL case of REQ-023 is applied -> S = 32'h0 on that edge, then 32'h8F0F8300 on the next edge with reset low.
